// File: rtl/fir_decim_pkg.sv
// rtl/fir_decim_pkg.sv - shared audio-chain constants, dequantize helper and FIR state type
package macros;

    localparam int BITS           = 10;
    localparam int AUDIO_DECIM    = 8;
    localparam int AUDIO_LPR_TAPS = 32;

    // Symmetric low-pass taps, quantized by BITS (DC gain 1040/1024)
    localparam logic signed [31:0] AUDIO_LPR_COEFFS [0:AUDIO_LPR_TAPS-1] = '{
        -32'sd2, -32'sd3, -32'sd4, -32'sd4, -32'sd2,  32'sd3, 32'sd10, 32'sd18,
         32'sd28, 32'sd40, 32'sd52, 32'sd63, 32'sd72, 32'sd79, 32'sd84, 32'sd86,
         32'sd86, 32'sd84, 32'sd79, 32'sd72, 32'sd63, 32'sd52, 32'sd40, 32'sd28,
         32'sd18, 32'sd10,  32'sd3, -32'sd2, -32'sd4, -32'sd4, -32'sd3, -32'sd2
    };

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} fir_state_t;

    // Arithmetic shift floors toward minus infinity for negative products
    function automatic logic signed [127:0] dequantize(input logic signed [127:0] p,
                                                       input int unsigned bits);
        return p >>> bits;
    endfunction

endpackage

// File: rtl/fir_decim_mac.sv
// rtl/fir_decim_mac.sv - registered multiply / dequantize / accumulate slice
module fir_mac
    import macros::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 10
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear_i,
    input  logic                         en_i,
    input  logic signed [DATA_WIDTH-1:0] x_i,
    input  logic signed [DATA_WIDTH-1:0] coeff_i,
    output logic signed [DATA_WIDTH-1:0] sum_o
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [DATA_WIDTH-1:0]   term;
    logic signed [DATA_WIDTH-1:0]   acc_q, acc_d;

    assign prod  = x_i * coeff_i;
    assign term  = DATA_WIDTH'(dequantize(128'(prod), FRAC_BITS));
    // Wraps modulo 2^DATA_WIDTH on purpose; the downstream IIR expects it
    assign sum_o = acc_q + term;

    always_comb begin
        acc_d = acc_q;
        if (clear_i)
            acc_d = '0;
        else if (en_i)
            acc_d = sum_o;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

endmodule

// File: rtl/fir_decim.sv
// rtl/fir_decim.sv - tap-serial decimating audio low-pass FIR
module fir_decim
    import macros::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_TAPS   = 32,
    parameter int DECIM      = 8,
    parameter int BITS       = macros::BITS,
    parameter logic signed [DATA_WIDTH-1:0] COEFFS [0:NUM_TAPS-1] = macros::AUDIO_LPR_COEFFS
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int TW = $clog2(NUM_TAPS);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

    fir_state_t                  state_q, state_d;
    logic signed [DATA_WIDTH-1:0] x_q [NUM_TAPS];
    logic [TW-1:0]               tap_q, tap_d;
    logic [PW-1:0]               phase_q, phase_d;
    logic signed [DATA_WIDTH-1:0] out_q, out_d;
    logic signed [DATA_WIDTH-1:0] sum;
    logic                        accept, last_tap, mac_clear, mac_en;

    assign accept    = in_valid && (state_q == S_IDLE);
    assign last_tap  = (tap_q == TW'(NUM_TAPS - 1));
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign out_data  = out_q;

    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        phase_d   = phase_q;
        out_d     = out_q;
        mac_clear = 1'b0;
        mac_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (phase_q == PW'(DECIM - 1)) begin
                        phase_d   = '0;
                        tap_d     = '0;
                        mac_clear = 1'b1;
                        state_d   = S_MAC;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            S_MAC: begin
                mac_en = 1'b1;
                tap_d  = tap_q + 1'b1;
                // Capture the combinational sum so the last product lands in out_data
                if (last_tap) begin
                    out_d   = sum;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            tap_q   <= '0;
            phase_q <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            phase_q <= phase_d;
            out_q   <= out_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_TAPS; k++)
                x_q[k] <= '0;
        end else if (accept) begin
            x_q[0] <= in_data;
            for (int k = 1; k < NUM_TAPS; k++)
                x_q[k] <= x_q[k-1];
        end
    end

    fir_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (BITS)
    ) u_mac (
        .clock   (clock),
        .reset   (reset),
        .clear_i (mac_clear),
        .en_i    (mac_en),
        .x_i     (x_q[tap_q]),
        .coeff_i (COEFFS[tap_q]),
        .sum_o   (sum)
    );

endmodule

// File: tb/tb_fir_decim.sv
// tb/tb_fir_decim.sv - directed self-checking bench for fir_decim
module tb_fir_decim;

    localparam logic signed [31:0] RAMP_C [0:31] = '{
        32'sd1,  32'sd2,  32'sd3,  32'sd4,  32'sd5,  32'sd6,  32'sd7,  32'sd8,
        32'sd9,  32'sd10, 32'sd11, 32'sd12, 32'sd13, 32'sd14, 32'sd15, 32'sd16,
        32'sd17, 32'sd18, 32'sd19, 32'sd20, 32'sd21, 32'sd22, 32'sd23, 32'sd24,
        32'sd25, 32'sd26, 32'sd27, 32'sd28, 32'sd29, 32'sd30, 32'sd31, 32'sd32
    };
    localparam logic signed [31:0] FLAT_C [0:31] = '{default: 32'sd179};

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic signed [31:0] in_data = '0;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b1;
    logic               rdy_r, rdy_f, rdy_d;
    logic               ov_r, ov_f, ov_d;
    logic signed [31:0] od_r, od_f, od_d;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_n = 0;
    int acc_cyc = 0;
    logic prev_ov = 1'b0;
    int q_r[$], q_f[$], q_d[$], lat_q[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    fir_decim #(.COEFFS(RAMP_C)) u_ramp (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_r), .out_data(od_r), .out_valid(ov_r), .out_ready(out_ready));
    fir_decim #(.COEFFS(FLAT_C)) u_flat (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_f), .out_data(od_f), .out_valid(ov_f), .out_ready(out_ready));
    fir_decim u_dflt (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_d), .out_data(od_d), .out_valid(ov_d), .out_ready(out_ready));

    // Transfers sampled mid-cycle complete on the next rising edge
    always @(negedge clock) begin
        if (ov_r && out_ready) q_r.push_back(od_r);
        if (ov_f && out_ready) q_f.push_back(od_f);
        if (ov_d && out_ready) q_d.push_back(od_d);
        if (in_valid && rdy_r) begin
            acc_n++;
            if (acc_n % 8 == 0) acc_cyc = cyc + 1;
        end
        if (ov_r && !prev_ov) lat_q.push_back(cyc - acc_cyc);
        prev_ov = ov_r;
    end

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        q_r.delete(); q_f.delete(); q_d.delete(); lat_q.delete();
        acc_n = 0;
        prev_ov = 1'b0;
    endtask

    task automatic push(input logic signed [31:0] d);
        int n = 0;
        @(negedge clock);
        in_data = d;
        in_valid = 1'b1;
        while (!rdy_r && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (!rdy_r) check("push_timeout", 0, 1);
        @(posedge clock);
    endtask

    task automatic end_push();
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int t = 0;
        while (q_r.size() < n && t < 1000) begin
            @(negedge clock);
            t++;
        end
        if (q_r.size() < n) check("wait_out_timeout", q_r.size(), n);
    endtask

    task automatic run_impulse(input logic signed [31:0] amp, input string tag);
        push(amp);
        repeat (39) push(0);
        end_push();
        wait_out(5);
        for (int j = 0; j < 5; j++) begin
            check($sformatf("%s_y%0d", tag, j), (j < q_r.size()) ? q_r[j] : -999,
                  (j < 4) ? (amp / 1024) * 8 * (j + 1) : 0);
            check($sformatf("%s_lat%0d", tag, j), (j < lat_q.size()) ? lat_q[j] : -1, 32);
        end
    endtask

    function automatic int ramp_model(input int n);
        int y = 0;
        for (int k = 0; k < 32; k++)
            if (n - k >= 0) y += (k + 1) * (n - k + 1);
        return y;
    endfunction

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_out_valid", ov_r, 0);
        check("rst_out_data", od_r, 0);
        reset = 1'b0;
        @(negedge clock);
        check("rst_in_ready", {rdy_r, rdy_f, rdy_d}, 3'b111);

        do_reset();
        run_impulse(1024, "imp");

        do_reset();
        run_impulse(-1024, "neg");

        do_reset();
        repeat (8) push(1);
        repeat (8) push(-1);
        end_push();
        wait_out(2);
        check("floor_y0", (q_f.size() > 0) ? q_f[0] : -999, 0);
        check("floor_y1", (q_f.size() > 1) ? q_f[1] : -999, -8);

        do_reset();
        repeat (64) push(1024);
        end_push();
        wait_out(8);
        for (int j = 3; j < 8; j++)
            check($sformatf("dc_y%0d", j), (j < q_d.size()) ? q_d[j] : -999, 1040);

        do_reset();
        out_ready = 1'b0;
        fork
            begin
                for (int n = 0; n < 32; n++) push(1024 * (n + 1));
                end_push();
            end
            begin
                int t = 0;
                logic signed [31:0] held;
                while (!ov_r && t < 500) begin
                    @(negedge clock);
                    t++;
                end
                check("bp_valid_seen", ov_r, 1);
                held = od_r;
                repeat (20) begin
                    @(negedge clock);
                    check("bp_hold_data", od_r, held);
                    check("bp_in_ready", rdy_r, 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_out(4);
        for (int j = 0; j < 4; j++)
            check($sformatf("bp_y%0d", j), (j < q_r.size()) ? q_r[j] : -999,
                  ramp_model(8 * j + 7));

        do_reset();
        push(1024);
        repeat (7) push(0);
        end_push();
        repeat (10) @(posedge clock);
        #2 reset = 1'b1;
        #1 check("mid_rst_valid", ov_r, 0);
        check("mid_rst_noout", q_r.size(), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        q_r.delete(); lat_q.delete();
        acc_n = 0;
        prev_ov = 1'b0;
        run_impulse(1024, "replay");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fir_decim.md
Name: fir_decim

Overview:
- Real-valued audio low-pass FIR with integer decimation, feeding the de-emphasis IIR in the FM receive chain.
- Consumes demodulated baseband samples at the pre-decimation rate. Emits one filtered sample per DECIM accepted inputs.
- Tap-serial: one multiply-accumulate per clock, so a single multiplier serves all taps.
- Valid/ready on both sides. Downstream IIR is fed from out_data when out_valid is high.

Parameters:
- DATA_WIDTH, 32, sample, coefficient and accumulator width (signed two's complement).
- NUM_TAPS, 32, filter length; must be >= 2 and >= DECIM.
- DECIM, 8, decimation factor; must be >= 1.
- BITS, 10, fixed-point fraction bits; quantized 1.0 = 1024.
- COEFFS, macros::AUDIO_LPR_COEFFS, array [0:NUM_TAPS-1] of signed DATA_WIDTH-bit coefficients, quantized by BITS.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  DATA_WIDTH  signed input sample.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  DATA_WIDTH  signed filtered, decimated sample.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream consumes out_data this cycle.

Behaviour:
- Reset is asynchronous, active-high. It clears:
  - sample history x[0..NUM_TAPS-1], phase counter, tap index and accumulator to 0;
  - state to S_IDLE, out_data to 0, out_valid to 0.
  - in_ready is 1 once reset deasserts.
- Reset mid-operation aborts any MAC or pending output. No partial output ever appears.
- Handshake:
  - Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
  - in_ready and out_valid are registered, never combinational from the other side.
- States:
  - S_IDLE: in_ready=1, out_valid=0.
    - On an input transfer: shift history (x[k] <= x[k-1], x[0] <= in_data), then increment the phase counter.
    - If the counter was DECIM-1: counter <= 0, acc <= 0, tap <= 0, go to S_MAC.
    - Otherwise stay in S_IDLE.
  - S_MAC: in_ready=0. Each cycle: acc <= acc + DEQUANTIZE(x[tap]*COEFFS[tap]), tap <= tap+1.
    - On the cycle tap == NUM_TAPS-1: out_data <= the final sum, go to S_OUT.
  - S_OUT: in_ready=0, out_valid=1, out_data held stable.
    - On an output transfer: go to S_IDLE. in_ready rises the following cycle.
- Latency: out_valid rises exactly NUM_TAPS clocks after the edge that accepted the DECIM-th sample.
- Throughput: at most one input per cycle in S_IDLE. Decimation phase is 0 after reset, so the first output follows the DECIM-th accepted sample.
- Arithmetic:
  - The product is a full 2*DATA_WIDTH signed value.
  - DEQUANTIZE is an arithmetic right shift by BITS (floor, not truncate-toward-zero), then truncation to DATA_WIDTH.
  - Each product is dequantized before accumulation.
  - The accumulator wraps modulo 2^DATA_WIDTH with no saturation, matching the downstream IIR.
- Backpressure: out_ready low holds S_OUT indefinitely. in_ready stays 0, so upstream stalls and no sample is dropped or duplicated.
- in_valid while in_ready=0 has no effect. in_data is ignored when in_valid=0.
- Taps are indexed newest-first: x[0] is the most recent sample, x[k] = x[n-k].

Decomposition:
- Shared package macros holds:
  - BITS and the DEQUANTIZE function (arithmetic shift);
  - AUDIO_DECIM = 8 and AUDIO_LPR_TAPS = 32;
  - the AUDIO_LPR_COEFFS constant array;
  - the state enum type fir_state_t {S_IDLE, S_MAC, S_OUT}.
- One natural sub-module: fir_mac, a registered multiply / dequantize / accumulate slice (clear, enable, x, coeff -> acc). Everything else is a single module.

Test Plan:
- Impulse
  - Stimulus: COEFFS overridden to h[k] = k+1; in_data = 1024, then 39 zeros, continuous valid, out_ready = 1.
  - Response: outputs 8, 16, 24, 32, 0; each out_valid exactly 32 clocks after every 8th accept.
- Negative impulse
  - Stimulus: same as impulse, first sample -1024.
  - Response: outputs -8, -16, -24, -32, 0.
- Floor rounding
  - Stimulus: all COEFFS = 179; 8 samples of +1, then 8 samples of -1 (prior history 0).
  - Response: first output 0. Second output -8 (8 taps at -1 floor to -1 each; 8 taps at +1 give 0).
- DC gain
  - Stimulus: default COEFFS, in_data constant 1024 for 64 samples.
  - Response: outputs 4 through 8 equal the sum of AUDIO_LPR_COEFFS.
- Backpressure
  - Stimulus: out_ready low for 20 cycles at the first out_valid while in_valid stays high.
  - Response: out_data stable, in_ready = 0 throughout; zero lost samples across 3 subsequent outputs vs. golden model.
- Reset mid-MAC
  - Stimulus: assert reset at tap 10 of the first computation, then replay the impulse test.
  - Response: no output before reset; post-reset outputs identical to the impulse test.
